// File: rtl/pucch_pkg.sv
// Shared constants, state type and modular-add helper for the PUCCH format 1 sequencer.
package pucch_pkg;

  localparam int CYC_DIV_DEF   = 24;
  localparam int N_SC_DEF      = 12;
  localparam int N_SYM_MAX_DEF = 14;
  localparam int N_SYM_MIN     = 4;
  localparam int N_CS          = 12;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Modulation phases as odd multiples of CYC_DIV/8
  localparam int BPSK_K0  = 1;
  localparam int BPSK_K1  = 5;
  localparam int QPSK_K00 = 1;
  localparam int QPSK_K01 = 7;
  localparam int QPSK_K10 = 3;
  localparam int QPSK_K11 = 5;

  function automatic logic [4:0] add_mod(input logic [4:0] a, input logic [4:0] b, input int m);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (int'(s) >= m) s = s - 6'(m);
    return s[4:0];
  endfunction

endpackage

// File: rtl/bpsk_cyc.sv
// BPSK modulation phase: maps b(0) onto an odd multiple of CYC_DIV/8.
module bpsk_cyc
  import pucch_pkg::*;
#(
  parameter int CYC_DIV = CYC_DIV_DEF
) (
  input  logic       i_b,
  output logic [4:0] o_cyc_part
);

  localparam logic [4:0] PH0 = 5'((BPSK_K0 * (CYC_DIV / 8)) % CYC_DIV);
  localparam logic [4:0] PH1 = 5'((BPSK_K1 * (CYC_DIV / 8)) % CYC_DIV);

  assign o_cyc_part = i_b ? PH1 : PH0;

endmodule

// File: rtl/qpsk_cyc.sv
// QPSK modulation phase: maps the pair b(0)b(1) onto an odd multiple of CYC_DIV/8.
module qpsk_cyc
  import pucch_pkg::*;
#(
  parameter int CYC_DIV = CYC_DIV_DEF
) (
  input  logic [1:0] i_b,
  output logic [4:0] o_cyc_part
);

  localparam logic [4:0] PH00 = 5'((QPSK_K00 * (CYC_DIV / 8)) % CYC_DIV);
  localparam logic [4:0] PH01 = 5'((QPSK_K01 * (CYC_DIV / 8)) % CYC_DIV);
  localparam logic [4:0] PH10 = 5'((QPSK_K10 * (CYC_DIV / 8)) % CYC_DIV);
  localparam logic [4:0] PH11 = 5'((QPSK_K11 * (CYC_DIV / 8)) % CYC_DIV);

  always_comb begin
    o_cyc_part = PH00;
    case ({i_b[0], i_b[1]})
      2'b00:   o_cyc_part = PH00;
      2'b01:   o_cyc_part = PH01;
      2'b10:   o_cyc_part = PH10;
      default: o_cyc_part = PH11;
    endcase
  end

endmodule

// File: rtl/pucch_f1_seq_ctrl.sv
// Accepts one HARQ-ACK job and streams a registered phase index per subcarrier per symbol.
// First element one cycle after accept; counters and outputs freeze while i_ready is low.
module pucch_f1_seq_ctrl
  import pucch_pkg::*;
#(
  parameter int CYC_DIV   = CYC_DIV_DEF,
  parameter int N_SC      = N_SC_DEF,
  parameter int N_SYM_MAX = N_SYM_MAX_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_nbits,
  input  logic [1:0] i_bits,
  input  logic [3:0] i_nsym,
  input  logic [3:0] i_cs,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [4:0] o_cyc,
  output logic [3:0] o_sc,
  output logic [3:0] o_sym,
  output logic       o_is_dmrs,
  output logic       o_last,
  output logic       o_busy
);

  localparam logic [4:0] STEP_U  = 5'(CYC_DIV / N_CS);
  localparam logic [3:0] SC_LAST = 4'(N_SC - 1);

  if ((CYC_DIV % 24) != 0 || CYC_DIV > 31) begin : g_bad_cyc_div
    $error("CYC_DIV must be a multiple of 24 and no larger than 31");
  end

  state_t     state, state_d;
  logic       nbits_q, nbits_d;
  logic [1:0] bits_q, bits_d;
  logic [3:0] nsym_m1_q, nsym_m1_d;
  logic [4:0] step_q, step_d;
  logic [4:0] acc_q, acc_d;
  logic       valid_d, dmrs_d, last_d;
  logic [4:0] cyc_d;
  logic [3:0] sc_d, sym_d;

  logic [3:0] nsym_c, cs_c;
  logic [4:0] bpsk_mph, qpsk_mph, mph;
  logic [3:0] sc_nx, sym_nx;
  logic [4:0] acc_nx, step_nx;
  logic       dmrs_nx;

  bpsk_cyc #(.CYC_DIV(CYC_DIV)) u_bpsk (
    .i_b        (bits_q[0]),
    .o_cyc_part (bpsk_mph)
  );

  qpsk_cyc #(.CYC_DIV(CYC_DIV)) u_qpsk (
    .i_b        (bits_q),
    .o_cyc_part (qpsk_mph)
  );

  assign mph         = nbits_q ? qpsk_mph : bpsk_mph;
  assign o_req_ready = (state == IDLE);
  assign o_busy      = (state == RUN);

  always_comb begin
    nsym_c = i_nsym;
    if (i_nsym < 4'(N_SYM_MIN))      nsym_c = 4'(N_SYM_MIN);
    else if (i_nsym > 4'(N_SYM_MAX)) nsym_c = 4'(N_SYM_MAX);
    cs_c = (i_cs >= 4'(N_CS)) ? i_cs - 4'(N_CS) : i_cs;
  end

  // Next element: the step advances by one shift unit per symbol, so cs_l is never multiplied out
  always_comb begin
    sc_nx   = o_sc + 4'd1;
    sym_nx  = o_sym;
    acc_nx  = add_mod(acc_q, step_q, CYC_DIV);
    step_nx = step_q;
    if (o_sc == SC_LAST) begin
      sc_nx   = '0;
      sym_nx  = o_sym + 4'd1;
      acc_nx  = '0;
      step_nx = add_mod(step_q, STEP_U, CYC_DIV);
    end
    dmrs_nx = ~sym_nx[0];
  end

  always_comb begin
    state_d   = state;
    nbits_d   = nbits_q;
    bits_d    = bits_q;
    nsym_m1_d = nsym_m1_q;
    step_d    = step_q;
    acc_d     = acc_q;
    valid_d   = o_valid;
    cyc_d     = o_cyc;
    sc_d      = o_sc;
    sym_d     = o_sym;
    dmrs_d    = o_is_dmrs;
    last_d    = o_last;
    case (state)
      IDLE: begin
        if (i_req_valid) begin
          state_d   = RUN;
          nbits_d   = i_nbits;
          bits_d    = i_bits;
          nsym_m1_d = nsym_c - 4'd1;
          step_d    = 5'((int'(cs_c) * int'(STEP_U)) % CYC_DIV);
          acc_d     = '0;
          valid_d   = 1'b1;
          cyc_d     = '0;
          sc_d      = '0;
          sym_d     = '0;
          dmrs_d    = 1'b1;
          last_d    = 1'b0;
        end
      end
      RUN: begin
        if (i_ready) begin
          if (o_last) begin
            state_d = IDLE;
            step_d  = '0;
            acc_d   = '0;
            valid_d = 1'b0;
            cyc_d   = '0;
            sc_d    = '0;
            sym_d   = '0;
            dmrs_d  = 1'b0;
            last_d  = 1'b0;
          end else begin
            step_d = step_nx;
            acc_d  = acc_nx;
            sc_d   = sc_nx;
            sym_d  = sym_nx;
            dmrs_d = dmrs_nx;
            cyc_d  = dmrs_nx ? acc_nx : add_mod(acc_nx, mph, CYC_DIV);
            last_d = (sym_nx == nsym_m1_q) && (sc_nx == SC_LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      nbits_q   <= 1'b0;
      bits_q    <= '0;
      nsym_m1_q <= '0;
      step_q    <= '0;
      acc_q     <= '0;
      o_valid   <= 1'b0;
      o_cyc     <= '0;
      o_sc      <= '0;
      o_sym     <= '0;
      o_is_dmrs <= 1'b0;
      o_last    <= 1'b0;
    end else begin
      nbits_q   <= nbits_d;
      bits_q    <= bits_d;
      nsym_m1_q <= nsym_m1_d;
      step_q    <= step_d;
      acc_q     <= acc_d;
      o_valid   <= valid_d;
      o_cyc     <= cyc_d;
      o_sc      <= sc_d;
      o_sym     <= sym_d;
      o_is_dmrs <= dmrs_d;
      o_last    <= last_d;
    end
  end

endmodule

// File: tb/tb_pucch_f1_seq_ctrl.sv
// Randomised scenario bench for pucch_f1_seq_ctrl against an arithmetic phase model.
module tb_pucch_f1_seq_ctrl;

  typedef struct packed {
    logic [4:0] cyc;
    logic [3:0] sc;
    logic [3:0] sym;
    logic       dmrs;
    logic       last;
  } elem_t;

  typedef struct packed {
    logic       nbits;
    logic [1:0] bits;
    logic [3:0] nsym;
    logic [3:0] cs;
  } job_t;

  localparam logic [17:0] RST_VAL = 18'h20000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       nbits = 1'b0;
  logic [1:0] bits = '0;
  logic [3:0] nsym = '0;
  logic [3:0] cs = '0;
  logic       valid;
  logic       ready = 1'b1;
  logic [4:0] cyc;
  logic [3:0] sc, sym;
  logic       is_dmrs, last, busy;

  int    n_vec = 0;
  int    n_err = 0;
  int    stall_bad, busy_bad;
  elem_t got_q[$];
  elem_t exp_q[$];

  pucch_f1_seq_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_nbits     (nbits),
    .i_bits      (bits),
    .i_nsym      (nsym),
    .i_cs        (cs),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_cyc       (cyc),
    .o_sc        (sc),
    .o_sym       (sym),
    .o_is_dmrs   (is_dmrs),
    .o_last      (last),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [17:0] out_vec();
    return {req_ready, valid, cyc, sc, sym, is_dmrs, last, busy};
  endfunction

  function automatic elem_t cur_elem();
    elem_t e;
    e.cyc = cyc; e.sc = sc; e.sym = sym; e.dmrs = is_dmrs; e.last = last;
    return e;
  endfunction

  function automatic int mph_of(job_t j);
    if (!j.nbits) return j.bits[0] ? 15 : 3;
    case ({j.bits[0], j.bits[1]})
      2'b00:   return 3;
      2'b01:   return 21;
      2'b10:   return 9;
      default: return 15;
    endcase
  endfunction

  // Expected stream: phase = n * cs_l * (24/12) plus mph on odd symbols, all mod 24
  function automatic void build_exp(job_t j);
    int ns, c0, ph, csl;
    elem_t e;
    exp_q.delete();
    ns = (j.nsym < 4) ? 4 : ((j.nsym > 14) ? 14 : int'(j.nsym));
    c0 = int'(j.cs) % 12;
    ph = mph_of(j);
    for (int l = 0; l < ns; l++) begin
      csl = (c0 + l) % 12;
      for (int n = 0; n < 12; n++) begin
        e.cyc  = 5'((n * csl * 2 + (((l % 2) == 1) ? ph : 0)) % 24);
        e.sc   = 4'(n);
        e.sym  = 4'(l);
        e.dmrs = ((l % 2) == 0);
        e.last = (l == ns - 1) && (n == 11);
        exp_q.push_back(e);
      end
    end
  endfunction

  // Called on a falling edge with the DUT idle; returns on the falling edge after the last accept.
  task automatic collect(input job_t j, input int stall_pct, input bit hold, input job_t nxt);
    elem_t e, prev;
    bit    prev_stall, done;
    int    cycles;
    got_q.delete();
    stall_bad = 0; busy_bad = 0; prev_stall = 0; done = 0; prev = '0; cycles = 0;
    nbits = j.nbits; bits = j.bits; nsym = j.nsym; cs = j.cs;
    req_valid = 1'b1; ready = 1'b1;
    @(negedge clk);
    if (hold) begin
      nbits = nxt.nbits; bits = nxt.bits; nsym = nxt.nsym; cs = nxt.cs;
    end else begin
      req_valid = 1'b0;
    end
    while (!done && cycles < 2000) begin
      if (valid) begin
        e = cur_elem();
        if (prev_stall && e !== prev) stall_bad++;
        if (busy !== 1'b1 || req_ready !== 1'b0) busy_bad++;
        ready = ($urandom_range(0, 99) >= stall_pct);
        if (ready) begin
          got_q.push_back(e);
          if (e.last) done = 1;
        end
        prev_stall = !ready;
        prev = e;
      end else begin
        if (prev_stall) stall_bad++;
        prev_stall = 0;
        ready = 1'b1;
      end
      @(negedge clk);
      cycles++;
    end
    ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (out_vec() !== RST_VAL) begin
      n_err++; $display("FAIL reset_held: got %b expected %b", out_vec(), RST_VAL);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_vec() !== RST_VAL) begin
      n_err++; $display("FAIL reset_released: got %b expected %b", out_vec(), RST_VAL);
    end
  endtask

  task automatic test_bpsk();
    job_t j;
    int   nlast;
    j = '{nbits: 1'b0, bits: 2'b00, nsym: 4'd4, cs: 4'd0};
    build_exp(j);
    collect(j, 0, 1'b0, j);
    n_vec++;
    if (got_q.size() != 48) begin
      n_err++; $display("FAIL bpsk_len: got %0d expected 48", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL bpsk_elem %0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() == 48) begin
      n_vec++;
      if (got_q[12].cyc !== 5'd3 || got_q[13].cyc !== 5'd5 || got_q[23].cyc !== 5'd1) begin
        n_err++; $display("FAIL bpsk_l1: got %0d %0d %0d expected 3 5 1",
                          got_q[12].cyc, got_q[13].cyc, got_q[23].cyc);
      end
      nlast = 0;
      foreach (got_q[i]) if (got_q[i].last) nlast++;
      n_vec++;
      if (nlast != 1 || got_q[47].last !== 1'b1) begin
        n_err++; $display("FAIL bpsk_last: got count %0d, elem47 %b expected 1, 1", nlast, got_q[47].last);
      end
    end
    n_vec++;
    if (valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL idle_after_job: got valid %b ready %b busy %b expected 0 1 0", valid, req_ready, busy);
    end
  endtask

  task automatic test_qpsk();
    job_t j;
    j = '{nbits: 1'b1, bits: 2'b10, nsym: 4'd4, cs: 4'd0};
    build_exp(j);
    collect(j, 0, 1'b0, j);
    n_vec++;
    if (got_q.size() != 48) begin
      n_err++; $display("FAIL qpsk_len: got %0d expected 48", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL qpsk_elem %0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() == 48) begin
      n_vec++;
      if (got_q[12].cyc !== 5'd21 || got_q[37].cyc !== 5'd3) begin
        n_err++; $display("FAIL qpsk_points: got %0d %0d expected 21 3", got_q[12].cyc, got_q[37].cyc);
      end
    end
  endtask

  task automatic test_wrap();
    job_t j;
    j = '{nbits: 1'b0, bits: 2'b01, nsym: 4'd14, cs: 4'd11};
    build_exp(j);
    collect(j, 0, 1'b0, j);
    n_vec++;
    if (got_q.size() != 168) begin
      n_err++; $display("FAIL wrap_len: got %0d expected 168", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL wrap_elem %0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
      if (got_q[i].sym == 4'd1 || got_q[i].sym == 4'd13) begin
        n_vec++;
        if (got_q[i].cyc !== 5'd15) begin
          n_err++; $display("FAIL wrap_cs0 sym %0d sc %0d: got %0d expected 15", got_q[i].sym, got_q[i].sc, got_q[i].cyc);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    job_t j;
    j = '{nbits: 1'b1, bits: 2'b11, nsym: 4'd14, cs: 4'($urandom_range(0, 11))};
    build_exp(j);
    collect(j, 40, 1'b0, j);
    n_vec++;
    if (stall_bad != 0) begin
      n_err++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_bad);
    end
    n_vec++;
    if (got_q.size() != 168) begin
      n_err++; $display("FAIL bp_len: got %0d expected 168", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL bp_elem %0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_busy_back_to_back();
    job_t j1, j2;
    j1 = '{nbits: 1'b0, bits: 2'b01, nsym: 4'd2, cs: 4'd5};
    j2 = '{nbits: 1'b1, bits: 2'b10, nsym: 4'd15, cs: 4'd14};
    build_exp(j1);
    collect(j1, 0, 1'b1, j2);
    n_vec++;
    if (busy_bad != 0) begin
      n_err++; $display("FAIL busy_hold: got %0d bad cycles expected 0", busy_bad);
    end
    n_vec++;
    if (got_q.size() != 48) begin
      n_err++; $display("FAIL b2b_first_len: got %0d expected 48", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL b2b_first_elem %0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if (valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_gap: got valid %b ready %b expected 0 1", valid, req_ready);
    end
    build_exp(j2);
    collect(j2, 0, 1'b0, j2);
    n_vec++;
    if (got_q.size() != 168) begin
      n_err++; $display("FAIL b2b_second_len: got %0d expected 168", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL b2b_second_elem %0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    job_t j;
    nbits = 1'b1; bits = 2'b00; nsym = 4'd14; cs = 4'd3;
    req_valid = 1'b1; ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (67) @(negedge clk);
    n_vec++;
    if (sym !== 4'd5 || sc !== 4'd7 || valid !== 1'b1) begin
      n_err++; $display("FAIL arst_position: got l %0d n %0d valid %b expected 5 7 1", sym, sc, valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_vec() !== RST_VAL) begin
      n_err++; $display("FAIL arst_immediate: got %b expected %b", out_vec(), RST_VAL);
    end
    @(negedge clk);
    rst_n = 1'b1;
    j = '{nbits: 1'b0, bits: 2'b01, nsym: 4'd6, cs: 4'($urandom_range(0, 15))};
    build_exp(j);
    collect(j, 20, 1'b0, j);
    n_vec++;
    if (got_q.size() != 72) begin
      n_err++; $display("FAIL arst_next_len: got %0d expected 72", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL arst_next_elem %0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    job_t j;
    int   pct;
    for (int k = 0; k < 6; k++) begin
      j.nbits = 1'($urandom_range(0, 1));
      j.bits  = 2'($urandom_range(0, 3));
      j.nsym  = 4'($urandom_range(0, 15));
      j.cs    = 4'($urandom_range(0, 15));
      pct     = $urandom_range(0, 50);
      build_exp(j);
      collect(j, pct, 1'b0, j);
      n_vec++;
      if (got_q.size() != exp_q.size() || stall_bad != 0) begin
        n_err++; $display("FAIL rand%0d_len: got %0d (stall errs %0d) expected %0d (0)",
                          k, got_q.size(), stall_bad, exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL rand%0d_elem %0d: got %h expected %h", k, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bpsk();
    test_qpsk();
    test_wrap();
    test_backpressure();
    test_busy_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
